// File: rtl/mips_multi_ctrl.sv
// mips_multi_ctrl: multi-cycle main control FSM for the MIPS core.
//
// Sequences a shared-ALU, single-memory datapath through fetch, decode,
// execute, memory and write-back steps. It handles R-type, LW, SW, BEQ, J,
// ADDIU and BGTZ. The FETCH, MEM_RD and MEM_WR steps wait on a
// variable-latency memory through mem_ready.
//
// Ports:
//   clk, rst        - clock (rising edge), asynchronous active-high reset
//   opcode          - instr[31:26] from the instruction register
//   mem_ready       - memory completes the current access this cycle
//   alu_zero, a_gtz - branch conditions for BEQ and BGTZ
//   pc_en, i_or_d, mem_read, mem_write, ir_write, mdr_write,
//   reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
//   pc_source       - datapath controls (combinational from state and inputs)
//   state           - current state, for debug
//   illegal         - one-cycle pulse when DECODE sees an unsupported opcode
//   retired         - count of completed instructions, wraps modulo 2^32
module mips_multi_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  opcode,
  input  logic        mem_ready,
  input  logic        alu_zero,
  input  logic        a_gtz,
  output logic        pc_en,
  output logic        i_or_d,
  output logic        mem_read,
  output logic        mem_write,
  output logic        ir_write,
  output logic        mdr_write,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        reg_write,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic [1:0]  pc_source,
  output logic [3:0]  state,
  output logic        illegal,
  output logic [31:0] retired
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXEC   = 4'd6,
    S_R_WB     = 4'd7,
    S_BEQ      = 4'd8,
    S_JUMP     = 4'd9,
    S_I_EXEC   = 4'd10,
    S_I_WB     = 4'd11,
    S_BGTZ     = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BGTZ  = 6'd7;
  localparam logic [5:0] OP_ADDIU = 6'd9;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  state_t state_q;
  state_t state_d;
  logic   retire;

  assign state = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      retired <= 32'd0;
    end else begin
      state_q <= state_d;
      if (retire) retired <= retired + 32'd1;
    end
  end

  // Outputs are gated by rst so that an aborted instruction cannot issue a
  // request or write while the reset is still held.
  always_comb begin
    state_d    = S_FETCH;
    retire     = 1'b0;
    pc_en      = 1'b0;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    mdr_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    pc_source  = 2'b00;
    illegal    = 1'b0;
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          ir_write  = mem_ready;
          pc_en     = mem_ready;
          state_d   = mem_ready ? S_DECODE : S_FETCH;
        end
        S_DECODE: begin
          // Branch target PC + (imm << 2) is precomputed here into ALUOut.
          alu_src_b = 2'b11;
          case (opcode)
            OP_RTYPE:     state_d = S_R_EXEC;
            OP_LW, OP_SW: state_d = S_MEM_ADDR;
            OP_BEQ:       state_d = S_BEQ;
            OP_J:         state_d = S_JUMP;
            OP_ADDIU:     state_d = S_I_EXEC;
            OP_BGTZ:      state_d = S_BGTZ;
            default: begin
              state_d = S_FETCH;
              illegal = 1'b1;
            end
          endcase
        end
        S_MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          state_d   = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
        end
        S_MEM_RD: begin
          i_or_d    = 1'b1;
          mem_read  = 1'b1;
          mdr_write = mem_ready;
          state_d   = mem_ready ? S_MEM_WB : S_MEM_RD;
        end
        S_MEM_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          retire     = 1'b1;
        end
        S_MEM_WR: begin
          i_or_d    = 1'b1;
          mem_write = 1'b1;
          retire    = mem_ready;
          state_d   = mem_ready ? S_FETCH : S_MEM_WR;
        end
        S_R_EXEC: begin
          alu_src_a = 1'b1;
          alu_op    = 2'b10;
          state_d   = S_R_WB;
        end
        S_R_WB: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
          retire    = 1'b1;
        end
        S_I_EXEC: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          state_d   = S_I_WB;
        end
        S_I_WB: begin
          reg_write = 1'b1;
          retire    = 1'b1;
        end
        S_BEQ: begin
          alu_src_a = 1'b1;
          alu_op    = 2'b01;
          pc_source = 2'b01;
          pc_en     = alu_zero;
          retire    = 1'b1;
        end
        S_BGTZ: begin
          pc_source = 2'b01;
          pc_en     = a_gtz;
          retire    = 1'b1;
        end
        S_JUMP: begin
          pc_source = 2'b10;
          pc_en     = 1'b1;
          retire    = 1'b1;
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_multi_ctrl.sv
// Directed testbench for mips_multi_ctrl.
module tb_mips_multi_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  opcode = 6'd0;
  logic        mem_ready = 1'b1;
  logic        alu_zero = 1'b0;
  logic        a_gtz = 1'b0;
  logic        pc_en, i_or_d, mem_read, mem_write, ir_write, mdr_write;
  logic        reg_dst, mem_to_reg, reg_write, alu_src_a, illegal;
  logic [1:0]  alu_src_b, alu_op, pc_source;
  logic [3:0]  state;
  logic [31:0] retired;

  int vectors = 0;
  int miscompares = 0;

  mips_multi_ctrl dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .alu_zero(alu_zero), .a_gtz(a_gtz), .pc_en(pc_en), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mdr_write(mdr_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .pc_source(pc_source), .state(state),
    .illegal(illegal), .retired(retired)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no summary, required completion");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [31:0] r0;
    rst = 1'b1;
    tick(); tick();
    vectors++;
    if ({state, retired} !== {4'd0, 32'd0}) begin
      miscompares++;
      $display("FAIL reset_state: got state=%0d retired=%0d, required 0 0", state, retired);
    end
    vectors++;
    if ({pc_en, ir_write, mdr_write, reg_write, mem_read, mem_write, illegal} !== 7'd0) begin
      miscompares++;
      $display("FAIL reset_enables: got %b, required 0000000",
               {pc_en, ir_write, mdr_write, reg_write, mem_read, mem_write, illegal});
    end
    vectors++;
    if ({i_or_d, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source} !== 10'd0) begin
      miscompares++;
      $display("FAIL reset_selects: got %b, required 0",
               {i_or_d, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source});
    end
    rst = 1'b0;
    #1;
    vectors++;
    if ({mem_read, ir_write, alu_src_b} !== 4'b1101) begin
      miscompares++;
      $display("FAIL release_fetch: got mem_read,ir_write,alu_src_b=%b, required 1101",
               {mem_read, ir_write, alu_src_b});
    end
    // One ADDIU so retired is non-zero before the mid-LW reset.
    opcode = 6'd9; mem_ready = 1'b1;
    repeat (4) tick();
    r0 = retired;
    vectors++;
    if (r0 !== 32'd1) begin
      miscompares++;
      $display("FAIL pre_lw_retired: got %0d, required 1", r0);
    end
    // LW into MEM_RD, stalled, then reset asynchronously.
    opcode = 6'd35;
    tick(); tick(); tick();
    mem_ready = 1'b0;
    #1;
    vectors++;
    if ({state, mem_read, i_or_d} !== {4'd3, 1'b1, 1'b1}) begin
      miscompares++;
      $display("FAIL lw_mem_rd: got state=%0d rd=%b iord=%b, required 3 1 1", state, mem_read, i_or_d);
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({state, retired} !== {4'd0, 32'd0}) begin
      miscompares++;
      $display("FAIL midlw_reset: got state=%0d retired=%0d, required 0 0", state, retired);
    end
    vectors++;
    if ({pc_en, ir_write, mdr_write, reg_write, mem_read, mem_write, i_or_d} !== 7'd0) begin
      miscompares++;
      $display("FAIL midlw_enables: got %b, required 0000000",
               {pc_en, ir_write, mdr_write, reg_write, mem_read, mem_write, i_or_d});
    end
    tick();
    rst = 1'b0; mem_ready = 1'b1;
    #1;
    vectors++;
    if ({state, mem_read, i_or_d} !== {4'd0, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL midlw_release: got state=%0d rd=%b iord=%b, required 0 1 0", state, mem_read, i_or_d);
    end
  endtask

  task automatic test_sequence;
    int         trace [20] = '{0,1,10,11, 0,1,6,7, 0,1,2,5, 0,1,2,3,4, 0,1,9};
    logic [5:0] ops   [20] = '{9,9,9,9, 0,0,0,0, 43,43,43,43, 35,35,35,35,35, 2,2,2};
    logic [3:0] st;
    logic       exp_rw, exp_wr, exp_dst, exp_m2r;
    mem_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      opcode = ops[i];
      #1;
      st = trace[i];
      vectors++;
      if (state !== st) begin
        miscompares++;
        $display("FAIL seq_state[%0d]: got %0d, required %0d", i, state, st);
      end
      exp_rw  = (st == 4'd4) || (st == 4'd7) || (st == 4'd11);
      exp_wr  = (st == 4'd5);
      exp_dst = (st == 4'd7);
      exp_m2r = (st == 4'd4);
      vectors++;
      if ({reg_write, mem_write, reg_dst, mem_to_reg} !== {exp_rw, exp_wr, exp_dst, exp_m2r}) begin
        miscompares++;
        $display("FAIL seq_ctrl[%0d]: got rw,wr,dst,m2r=%b, required %b", i,
                 {reg_write, mem_write, reg_dst, mem_to_reg}, {exp_rw, exp_wr, exp_dst, exp_m2r});
      end
      if (st == 4'd9) begin
        vectors++;
        if ({pc_en, pc_source} !== 3'b110) begin
          miscompares++;
          $display("FAIL seq_jump: got pc_en,pc_source=%b, required 110", {pc_en, pc_source});
        end
      end
      if (st == 4'd6) begin
        vectors++;
        if ({alu_src_a, alu_src_b, alu_op} !== 5'b10010) begin
          miscompares++;
          $display("FAIL seq_rexec: got %b, required 10010", {alu_src_a, alu_src_b, alu_op});
        end
      end
      tick();
    end
    vectors++;
    if ({state, retired} !== {4'd0, 32'd5}) begin
      miscompares++;
      $display("FAIL seq_retired: got state=%0d retired=%0d, required 0 5", state, retired);
    end
  endtask

  task automatic test_beq;
    logic [31:0] r0;
    r0 = retired;
    opcode = 6'd4; mem_ready = 1'b1;
    alu_zero = 1'b1;
    tick(); tick();
    vectors++;
    if ({state, pc_en, pc_source, alu_op} !== {4'd8, 1'b1, 2'b01, 2'b01}) begin
      miscompares++;
      $display("FAIL beq_taken: got state=%0d pc_en=%b src=%b op=%b, required 8 1 01 01",
               state, pc_en, pc_source, alu_op);
    end
    tick();
    alu_zero = 1'b0;
    tick(); tick();
    vectors++;
    if ({state, pc_en, pc_source} !== {4'd8, 1'b0, 2'b01}) begin
      miscompares++;
      $display("FAIL beq_not_taken: got state=%0d pc_en=%b src=%b, required 8 0 01", state, pc_en, pc_source);
    end
    tick();
    vectors++;
    if ({state, retired} !== {4'd0, r0 + 32'd2}) begin
      miscompares++;
      $display("FAIL beq_retired: got state=%0d retired=%0d, required 0 %0d", state, retired, r0 + 32'd2);
    end
  endtask

  task automatic test_bgtz;
    logic [31:0] r0;
    r0 = retired;
    opcode = 6'd7; mem_ready = 1'b1;
    a_gtz = 1'b0;
    tick(); tick();
    vectors++;
    if ({state, pc_en, pc_source} !== {4'd12, 1'b0, 2'b01}) begin
      miscompares++;
      $display("FAIL bgtz_not_taken: got state=%0d pc_en=%b src=%b, required 12 0 01", state, pc_en, pc_source);
    end
    tick();
    vectors++;
    if ({state, retired} !== {4'd0, r0 + 32'd1}) begin
      miscompares++;
      $display("FAIL bgtz_3cyc: got state=%0d retired=%0d, required 0 %0d", state, retired, r0 + 32'd1);
    end
    a_gtz = 1'b1;
    tick(); tick();
    vectors++;
    if ({state, pc_en} !== {4'd12, 1'b1}) begin
      miscompares++;
      $display("FAIL bgtz_taken: got state=%0d pc_en=%b, required 12 1", state, pc_en);
    end
    tick();
    a_gtz = 1'b0;
  endtask

  task automatic test_lw_stall;
    logic [31:0] r0;
    int ir_cnt, mdr_cnt;
    logic stall;
    r0 = retired; ir_cnt = 0; mdr_cnt = 0;
    opcode = 6'd35;
    for (int i = 0; i < 11; i++) begin
      stall = (i <= 2) || (i >= 6 && i <= 8);
      mem_ready = !stall;
      #1;
      if (ir_write)  ir_cnt++;
      if (mdr_write) mdr_cnt++;
      if (stall) begin
        vectors++;
        if ({mem_read, i_or_d, state} !== {1'b1, (i >= 6), (i >= 6) ? 4'd3 : 4'd0}) begin
          miscompares++;
          $display("FAIL lw_stall[%0d]: got rd=%b iord=%b state=%0d, required 1 %b %0d",
                   i, mem_read, i_or_d, state, (i >= 6), (i >= 6) ? 3 : 0);
        end
      end
      tick();
    end
    mem_ready = 1'b1;
    vectors++;
    if ({ir_cnt, mdr_cnt} !== {32'd1, 32'd1}) begin
      miscompares++;
      $display("FAIL lw_pulses: got ir=%0d mdr=%0d, required 1 1", ir_cnt, mdr_cnt);
    end
    vectors++;
    if ({state, retired} !== {4'd0, r0 + 32'd1}) begin
      miscompares++;
      $display("FAIL lw_11cyc: got state=%0d retired=%0d, required 0 %0d", state, retired, r0 + 32'd1);
    end
  endtask

  task automatic test_sw_stall;
    logic [31:0] r0;
    r0 = retired;
    opcode = 6'd43; mem_ready = 1'b1;
    tick(); tick(); tick();
    mem_ready = 1'b0;
    tick();
    vectors++;
    if ({state, mem_write, i_or_d, retired} !== {4'd5, 1'b1, 1'b1, r0}) begin
      miscompares++;
      $display("FAIL sw_hold: got state=%0d wr=%b iord=%b retired=%0d, required 5 1 1 %0d",
               state, mem_write, i_or_d, retired, r0);
    end
    mem_ready = 1'b1;
    tick();
    vectors++;
    if ({state, retired} !== {4'd0, r0 + 32'd1}) begin
      miscompares++;
      $display("FAIL sw_done: got state=%0d retired=%0d, required 0 %0d", state, retired, r0 + 32'd1);
    end
  endtask

  task automatic test_illegal;
    logic [31:0] r0;
    r0 = retired;
    opcode = 6'h3F; mem_ready = 1'b1;
    #1;
    vectors++;
    if (illegal !== 1'b0) begin
      miscompares++;
      $display("FAIL illegal_fetch: got %b, required 0", illegal);
    end
    tick();
    vectors++;
    if ({state, illegal} !== {4'd1, 1'b1}) begin
      miscompares++;
      $display("FAIL illegal_decode: got state=%0d illegal=%b, required 1 1", state, illegal);
    end
    tick();
    vectors++;
    if ({state, illegal, retired} !== {4'd0, 1'b0, r0}) begin
      miscompares++;
      $display("FAIL illegal_return: got state=%0d illegal=%b retired=%0d, required 0 0 %0d",
               state, illegal, retired, r0);
    end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_beq();
    test_bgtz();
    test_lw_stall();
    test_sw_stall();
    test_illegal();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
